// File: rtl/gecko_mem_arbiter_pkg.sv
// Shared types for the gecko memory arbiter: requester identities and the
// tie-break helper used by the round-robin grant.
package gecko_mem_arbiter_pkg;

  typedef enum logic {
    GECKO_MEM_REQ_FETCH = 1'b0,
    GECKO_MEM_REQ_DATA  = 1'b1
  } gecko_mem_requester_t;

  // The requester that wins a tie when `last` was granted most recently.
  function automatic gecko_mem_requester_t other_requester(input gecko_mem_requester_t last);
    return (last == GECKO_MEM_REQ_FETCH) ? GECKO_MEM_REQ_DATA : GECKO_MEM_REQ_FETCH;
  endfunction

endpackage

// File: rtl/gecko_mem_arbiter_if.sv
// Valid/ready memory channel carrying a read or masked-write command, or a
// read-data beat. "out" drives the payload, "in" returns ready.
interface std_mem_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [MASK_WIDTH-1:0] write_enable;

  modport in (
    input  valid, read_enable, addr, data, write_enable,
    output ready
  );

  modport out (
    output valid, read_enable, addr, data, write_enable,
    input  ready
  );

endinterface

// File: rtl/gecko_mem_arbiter_std_fifo.sv
// Small synchronous FIFO used to remember which requester owns each
// outstanding read, so responses can be steered back in request order.
module std_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers decide which
  // entries are meaningful, and leaving the array unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gecko_mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant into a single registered
// downstream command, with in-order read responses steered back by ID queue.
module gecko_mem_arbiter
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  std_mem_intf.in    fetch_command,
  std_mem_intf.out   fetch_result,
  std_mem_intf.in    data_command,
  std_mem_intf.out   data_result,
  std_mem_intf.out   mem_command,
  std_mem_intf.in    mem_result,
  output logic       protocol_error
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of two and at least 2");
  end

  logic                  fetch_eligible;
  logic                  data_eligible;
  logic                  grant_valid;
  logic                  can_load;
  logic                  accept;
  gecko_mem_requester_t  grant;
  gecko_mem_requester_t  last_grant;

  logic                  sel_read;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [MASK_WIDTH-1:0] sel_mask;

  logic                  cmd_valid;
  logic                  cmd_read;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [MASK_WIDTH-1:0] cmd_mask;

  logic                  id_full;
  logic                  id_empty;
  logic                  id_push;
  logic                  id_pop;
  logic [0:0]            id_push_bits;
  logic [0:0]            id_head_bits;
  gecko_mem_requester_t  id_head;

  // A full ID queue blocks only reads; writes need no response slot.
  assign fetch_eligible = fetch_command.valid && !(fetch_command.read_enable && id_full);
  assign data_eligible  = data_command.valid  && !(data_command.read_enable  && id_full);
  assign grant_valid    = fetch_eligible || data_eligible;
  assign can_load       = !cmd_valid || mem_command.ready;
  assign accept         = !rst && grant_valid && can_load;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    grant = GECKO_MEM_REQ_FETCH;
    if (fetch_eligible && data_eligible) grant = other_requester(last_grant);
    else if (data_eligible)              grant = GECKO_MEM_REQ_DATA;
  end

  assign fetch_command.ready = accept && (grant == GECKO_MEM_REQ_FETCH);
  assign data_command.ready  = accept && (grant == GECKO_MEM_REQ_DATA);

  always_comb begin
    sel_read = fetch_command.read_enable;
    sel_addr = fetch_command.addr;
    sel_data = fetch_command.data;
    sel_mask = fetch_command.write_enable;
    if (grant == GECKO_MEM_REQ_DATA) begin
      sel_read = data_command.read_enable;
      sel_addr = data_command.addr;
      sel_data = data_command.data;
      sel_mask = data_command.write_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid  <= 1'b0;
      last_grant <= GECKO_MEM_REQ_DATA;
    end else if (accept) begin
      cmd_valid  <= 1'b1;
      last_grant <= grant;
    end else if (mem_command.ready) begin
      cmd_valid  <= 1'b0;
    end
  end

  // Payload is qualified by cmd_valid, so it only loads on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_read <= sel_read;
      cmd_addr <= sel_addr;
      cmd_data <= sel_data;
      cmd_mask <= sel_mask;
    end
  end

  assign mem_command.valid        = cmd_valid;
  assign mem_command.read_enable  = cmd_read;
  assign mem_command.addr         = cmd_addr;
  assign mem_command.data         = cmd_data;
  assign mem_command.write_enable = cmd_mask;

  assign id_push      = accept && sel_read;
  assign id_push_bits = grant;
  assign id_head      = gecko_mem_requester_t'(id_head_bits);

  std_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (id_push),
    .push_data (id_push_bits),
    .pop       (id_pop),
    .head      (id_head_bits),
    .full      (id_full),
    .empty     (id_empty)
  );

  // Responses go straight through; with nothing outstanding the beat is
  // swallowed (ready=1) and flagged.
  always_comb begin
    fetch_result.valid = 1'b0;
    data_result.valid  = 1'b0;
    mem_result.ready   = 1'b1;
    if (!id_empty) begin
      if (id_head == GECKO_MEM_REQ_FETCH) begin
        fetch_result.valid = mem_result.valid;
        mem_result.ready   = fetch_result.ready;
      end else begin
        data_result.valid  = mem_result.valid;
        mem_result.ready   = data_result.ready;
      end
    end
  end

  assign id_pop = mem_result.valid && mem_result.ready && !id_empty;

  assign fetch_result.data         = mem_result.data;
  assign fetch_result.read_enable  = 1'b0;
  assign fetch_result.addr         = '0;
  assign fetch_result.write_enable = '0;
  assign data_result.data          = mem_result.data;
  assign data_result.read_enable   = 1'b0;
  assign data_result.addr          = '0;
  assign data_result.write_enable  = '0;

  always_ff @(posedge clk) begin
    if (rst)                                protocol_error <= 1'b0;
    else if (mem_result.valid && id_empty)  protocol_error <= 1'b1;
  end

  // Response beats carry only data; the command fields are ignored.
  logic unused_mem_result;
  assign unused_mem_result = ^{mem_result.read_enable, mem_result.addr, mem_result.write_enable};

endmodule

// File: doc/gecko_mem_arbiter.md
GECKO_MEM_ARBITER -- requirements
Module: gecko_mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, memory address width.
REQ-002 Parameter: DATA_WIDTH, 32, memory data width; write_enable mask is DATA_WIDTH/8 bits.
REQ-003 Parameter: MAX_OUTSTANDING, 4, read responses in flight; power of two, >= 2.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: fetch_command  std_mem_intf.in  ADDR/DATA  requester 0 (instruction fetch).
REQ-007 Port: fetch_result  std_mem_intf.out  DATA  read data returned to requester 0.
REQ-008 Port: data_command  std_mem_intf.in  ADDR/DATA  requester 1 (load/store).
REQ-009 Port: data_result  std_mem_intf.out  DATA  read data returned to requester 1.
REQ-010 Port: mem_command  std_mem_intf.out  ADDR/DATA  shared downstream memory port.
REQ-011 Port: mem_result  std_mem_intf.in  DATA  shared downstream read responses, in request order.
REQ-012 Port: protocol_error  out  1  sticky; mem_result beat arrived with no outstanding read.

Function
REQ-013 A command is a read iff read_enable=1; only reads produce a response; writes (read_enable=0) are fire-and-forget.
REQ-014 mem_command is a single output register: it loads a granted command when empty or when mem_command.ready=1 in the same cycle; request latency exactly 1 cycle.
REQ-015 Grant: only one valid requester -> grant it; both valid -> grant the requester not recorded in last_grant.
REQ-016 last_grant updates only on a cycle in which a command is accepted (valid && ready on that requester's command port).
REQ-017 Exactly the granted requester sees command.ready=1; the other sees 0; neither sees ready when the output register cannot load.
REQ-018 Each accepted read pushes its 1-bit requester ID into the ID queue, depth MAX_OUTSTANDING.
REQ-019 ID queue full (count at start of cycle == MAX_OUTSTANDING): no read is granted, even if a pop occurs that cycle; writes are still granted under REQ-015 (a pending read does not block the other requester's write).
REQ-020 Response routing is combinational, zero latency: queue head selects fetch_result or data_result; data and valid forwarded; mem_result.ready = ready of the selected port; unselected result valid = 0.
REQ-021 Pop on mem_result.valid && mem_result.ready; simultaneous push and pop keeps count unchanged; pointers wrap modulo MAX_OUTSTANDING.
REQ-022 mem_result.valid with queue empty: mem_result.ready = 1 (beat dropped), no result port asserted, protocol_error set and held until reset.
REQ-023 Responses never reorder: ID queue is strictly FIFO.

Reset
REQ-024 On rst: mem_command.valid=0, queue empty (count 0, pointers 0), last_grant=DATA (fetch wins the first tie), protocol_error=0.
REQ-025 Reset mid-operation discards the registered command and all outstanding IDs; responses arriving after reset are handled under REQ-022.
REQ-026 During rst all command.ready outputs are 0.

Structure
REQ-027 gecko package gains gecko_mem_requester_t enum (GECKO_MEM_REQ_FETCH=0, GECKO_MEM_REQ_DATA=1).
REQ-028 ID queue is one sub-module instance, std_fifo (WIDTH=1, DEPTH=MAX_OUTSTANDING); arbiter, output register and routing are inline.

Verification
REQ-029 After reset, fetch and data both valid reads every cycle, mem ready=1 -> mem_command order F,D,F,D; first command visible one cycle after accept.
REQ-030 Four fetch reads accepted, no responses (MAX_OUTSTANDING=4) -> fifth fetch read held ready=0; data write addr 0x100 mask 4'hF still issued.
REQ-031 Reads issued F(0x0),D(0x40),F(0x4); mem_result returns 0xA,0xB,0xC -> fetch_result gets 0xA then 0xC, data_result gets 0xB.
REQ-032 mem_command.ready=0 for 3 cycles with both requesters valid -> registered command stable, both command.ready=0, no queue change.
REQ-033 Queue full, same cycle one response popped and fetch read valid -> read not granted that cycle, granted next cycle, count returns to 4.
REQ-034 mem_result.valid with empty queue -> beat consumed, no result valid, protocol_error=1 until rst.
